mem_responder: RTL

// - On-chip block-RAM responder on the memory side of arbiter_sync_pri; drop-in replacement for the SDRAM controller.
// - Used for simulation and small frame/sample buffers.
// - Accepts single-word writes and burst reads (BURST words per read request).
// - Returns read data tagged with the requester id on mem_data/mem_id/mem_valid.

---
 rtl/mem_resp_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 16 +
 rtl/mem_responder_cmd_fifo.sv | 42 ++++
 rtl/mem_responder.sv | 89 ++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared sizes, read-command record and read-engine states for mem_responder
package mem_resp_pkg;
    localparam int AN     = 24;
    localparam int DN     = 16;
    localparam int IN     = 2;
    localparam int BURST  = 8;
    localparam int DEPTH  = 12;
    localparam int QN     = 2;
    localparam int OFFN   = $clog2(BURST);
    localparam int RD_LAT = 3;

    typedef struct packed {
        logic [DEPTH-1:0] base;
        logic [OFFN-1:0]  off;
        logic [IN-1:0]    id;
    } rd_cmd_t;

    typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

    // word k of a burst: offset wraps inside the aligned block, never carries into base
    function automatic logic [DEPTH-1:0] burst_addr(input rd_cmd_t c, input logic [OFFN-1:0] k);
        logic [OFFN-1:0] o;
        o = c.off + k;
        return c.base | {{(DEPTH-OFFN){1'b0}}, o};
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: client request bus plus tagged read-return bus
interface mem_responder_if;
    import mem_resp_pkg::*;
    logic [AN-1:0] addr;
    logic [DN-1:0] data;
    logic [IN-1:0] id;
    logic          req;
    logic          wr;
    logic          ack;
    logic [DN-1:0] mem_data;
    logic [IN-1:0] mem_id;
    logic          mem_valid;

    modport master (output addr, data, id, req, wr, input ack, mem_data, mem_id, mem_valid);
    modport slave  (input addr, data, id, req, wr, output ack, mem_data, mem_id, mem_valid);
endinterface

// File: rtl/mem_responder_cmd_fifo.sv
// resp_cmd_fifo: small synchronous queue of pending read commands
module resp_cmd_fifo
    import mem_resp_pkg::*;
(
    input  logic    clkSYS,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  rd_cmd_t din,
    output rd_cmd_t dout,
    output logic    full,
    output logic    empty
);
    rd_cmd_t        slots [2**QN];
    logic [QN-1:0]  wp, rp;
    logic [QN:0]    cnt;
    logic           do_push, do_pop;

    assign full    = cnt[QN];
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = slots[rp];

    // storage is not reset; only the pointers define what is valid
    always_ff @(posedge clkSYS) begin
        if (do_push) slots[wp] <= din;
    end

    // pointer and occupancy bookkeeping
    always_ff @(posedge clkSYS) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + QN'(do_push);
            rp  <= rp + QN'(do_pop);
            cnt <= cnt + (QN+1)'(do_push) - (QN+1)'(do_pop);
        end
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: block-RAM memory responder with single-word writes and wrapping burst reads
module mem_responder
    import mem_resp_pkg::*;
(
    input  logic            clkSYS,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    logic [DN-1:0]    ram [2**DEPTH];
    logic             ack, ack_q, push, pop, full, empty, we;
    logic [DEPTH-1:0] waddr, raddr;
    rd_cmd_t          new_cmd, head, cur;
    rd_state_t        state, next_state;
    logic [OFFN-1:0]  k;
    logic [DN-1:0]    data_q;
    logic [IN-1:0]    id_q;
    logic             valid_q;
    logic             unused_addr;

    // full is sampled before any pop this cycle, so a full queue refuses the push
    assign ack         = !reset && bus.req && !ack_q && (bus.wr || !full);
    assign push        = ack && !bus.wr;
    assign we          = ack && bus.wr;
    assign waddr       = bus.addr[DEPTH-1:0];
    assign new_cmd     = '{base: {waddr[DEPTH-1:OFFN], {OFFN{1'b0}}}, off: waddr[OFFN-1:0], id: bus.id};
    assign raddr       = burst_addr(cur, k);
    assign unused_addr = ^bus.addr[AN-1:DEPTH];

    assign bus.ack       = ack;
    assign bus.mem_data  = data_q;
    assign bus.mem_id    = id_q;
    assign bus.mem_valid = valid_q;

    resp_cmd_fifo u_fifo (
        .clkSYS (clkSYS),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .din    (new_cmd),
        .dout   (head),
        .full   (full),
        .empty  (empty)
    );

    // next command is taken when idle or on the last word of a burst, giving gapless bursts
    always_comb begin
        pop        = 1'b0;
        next_state = state;
        if (state == RD_IDLE || &k) begin
            pop        = !empty;
            next_state = empty ? RD_IDLE : RD_BURST;
        end
    end

    // read engine registers: state, current command and word counter
    always_ff @(posedge clkSYS) begin
        if (reset) begin
            state <= RD_IDLE;
            cur   <= '0;
            k     <= '0;
            ack_q <= 1'b0;
        end else begin
            state <= next_state;
            ack_q <= ack;
            k     <= (state == RD_BURST) ? k + 1'b1 : '0;
            if (pop) cur <= head;
        end
    end

    // write port of the RAM
    always_ff @(posedge clkSYS) begin
        if (we) ram[waddr] <= bus.data;
    end

    // registered read port; a same-cycle write to the read address is forwarded
    always_ff @(posedge clkSYS) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= state == RD_BURST;
            if (state == RD_BURST) begin
                data_q <= (we && waddr == raddr) ? bus.data : ram[raddr];
                id_q   <= cur.id;
            end
        end
    end
endmodule
